// File: rtl/display_pkg.sv
// display_pkg
//   Shared constants for the seven-segment scan driver.
//   Glyphs are active-high and ordered {g,f,e,d,c,b,a}.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg
//   Combinational BCD to seven-segment decoder, active-high output.
//   Codes 10..15 are not valid BCD and are shown as a dash.
// Ports:
//   bcd  in  4  digit code
//   seg  out 7  segments {g,f,e,d,c,b,a}
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver
//   Time-multiplexed seven-segment display driver with frame-synchronous
//   data update, leading-zero blanking and per-digit blinking.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   digits_bcd   in   4*NUM_DIGITS BCD digits, digit 0 in [3:0]
//   dp_in        in   NUM_DIGITS decimal point requests
//   load         in   strobe capturing digits_bcd / dp_in
//   blank_lz     in   leading-zero blanking enable (live)
//   blink_mask   in   per-digit blink enable (live)
//   seg          out  7 segments {g,f,e,d,c,b,a}, registered
//   dp           out  decimal point of enabled digit, registered
//   an           out  one-hot digit enable, registered
//   frame_done   out  pulse in the cycle the last digit's slot ends
module display_scan_driver
    import display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          tc;
    logic          frame_end;

    logic [NUM_DIGITS-1:0][3:0] in_dig, pend_dig, act_dig;
    logic [NUM_DIGITS-1:0]      pend_dp, act_dp;

    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;
    logic                  blank_now;
    logic [3:0]            cur_dig;
    logic [6:0]            glyph;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;

    assign in_dig    = digits_bcd;
    assign tc        = (presc == PW'(REFRESH_DIV - 1));
    assign frame_end = tc && (idx == IW'(NUM_DIGITS - 1));
    // Gated with rst_n so the pulse is quiet for the whole reset window,
    // including the first cycle before the counters have been cleared.
    assign frame_done = frame_end & rst_n;

    // Scan timing: prescaler and digit index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (tc) begin
            presc <= '0;
            idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Blink phase flips after BLINK_FRAMES completed frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Double-buffered digit data: the active copy only changes at a frame
    // boundary so a single frame never shows a mix of old and new values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_dig <= '0;
            pend_dp  <= '0;
            act_dig  <= '0;
            act_dp   <= '0;
        end else begin
            if (load) begin
                pend_dig <= in_dig;
                pend_dp  <= dp_in;
            end
            if (frame_end) begin
                act_dig <= load ? in_dig : pend_dig;
                act_dp  <= load ? dp_in  : pend_dp;
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while everything seen
    // so far is zero. Digit 0 is always shown.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run & (act_dig[i] == 4'd0);
            lz_blank[i] = blank_lz & zero_run;
        end
    end

    assign cur_dig   = act_dig[idx];
    assign blank_now = lz_blank[idx] | (~blink_on & blink_mask[idx]);

    bcd_to_7seg u_dec (
        .bcd (cur_dig),
        .seg (glyph)
    );

    // Output registers hold logical (active-high) levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b0;
            an_q  <= '0;
        end else begin
            seg_q <= blank_now ? SEG_BLANK : glyph;
            dp_q  <= ~blank_now & act_dp[idx];
            an_q  <= NUM_DIGITS'(1) << idx;
        end
    end

    // Pin polarity is applied only here.
    assign seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp  = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;
    assign an  = SEG_ACTIVE_LOW ? ~an_q  : an_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver
//   Randomized scoreboard bench. A reference model derives the expected
//   display from the elapsed cycle count since reset (slot = t/RD, digit =
//   slot mod N, frame = t/(RD*N)) and pushes one expectation per clock edge;
//   a monitor pops and compares shortly after each edge.
module tb_display_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4*N-1:0] digits_bcd = '0;
    logic [N-1:0]  dp_in = '0;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic [N-1:0]  blink_mask = '0;
    logic [6:0]    seg;
    logic          dp;
    logic [N-1:0]  an;
    logic          frame_done;

    int checks = 0;
    int failures = 0;

    display_scan_driver #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (RD),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_bcd (digits_bcd),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
        logic         fd;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [6:0] ref_glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // Reference model state.
    int             t = 0;
    logic [3:0]     m_act [N];
    logic [3:0]     m_pend[N];
    logic [N-1:0]   m_act_dp;
    logic [N-1:0]   m_pend_dp;

    always @(posedge clk) begin : model
        exp_t e;
        int   d;
        int   fr;
        bit   zr;
        bit   blank;
        bit   fend;
        e = '0;
        if (!rst_n) begin
            t = 0;
            for (int j = 0; j < N; j++) begin
                m_act[j]  = 4'd0;
                m_pend[j] = 4'd0;
            end
            m_act_dp  = '0;
            m_pend_dp = '0;
        end else begin
            d  = (t / RD) % N;
            fr = t / (RD * N);
            zr = 1'b1;
            for (int j = N - 1; j >= d; j--) zr = zr && (m_act[j] == 4'd0);
            blank = (blank_lz && d > 0 && zr) ||
                    (((fr / BF) % 2 == 1) && blink_mask[d]);
            e.seg = blank ? 7'd0 : ref_glyph(m_act[d]);
            e.dp  = !blank && m_act_dp[d];
            e.an  = N'(1) << d;
            fend  = ((t % RD) == RD - 1) && (d == N - 1);
            if (load) begin
                for (int j = 0; j < N; j++) m_pend[j] = digits_bcd[4*j +: 4];
                m_pend_dp = dp_in;
            end
            if (fend) begin
                for (int j = 0; j < N; j++) m_act[j] = m_pend[j];
                m_act_dp = m_pend_dp;
            end
            t++;
            e.fd = ((t % RD) == RD - 1) && (((t / RD) % N) == N - 1);
        end
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1 time=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("seg", 32'(seg), 32'(e.seg));
            chk("dp", 32'(dp), 32'(e.dp));
            chk("an", 32'(an), 32'(e.an));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
        end
    end

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] p);
        digits_bcd = v;
        dp_in      = p;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    function automatic logic [4*N-1:0] rand_digits();
        logic [4*N-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++)
            r[4*j +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // idle scan of zeros
        repeat (40) @(negedge clk);
        // mid-frame load
        repeat (5) @(negedge clk);
        do_load(16'h1259, 4'b0100);
        repeat (40) @(negedge clk);
        // leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0070, 4'b1000);
        repeat (40) @(negedge clk);
        do_load(16'h0000, 4'b0000);
        repeat (40) @(negedge clk);
        // invalid codes show as dash
        do_load(16'h00AF, 4'b0001);
        repeat (40) @(negedge clk);
        blank_lz = 1'b0;
        // blinking over several blink half-periods
        do_load(16'h4321, 4'b1111);
        blink_mask = 4'b0011;
        repeat (16 * 6) @(negedge clk);
        blink_mask = 4'b0000;
        // reset while a load is pending
        do_load(16'h9876, 4'b0110);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            load = ($urandom % 4 == 0);
            if (load) begin
                digits_bcd = rand_digits();
                dp_in      = N'($urandom);
            end
            if ($urandom % 64 == 0) blank_lz = 1'($urandom);
            if ($urandom % 64 == 0) blink_mask = N'($urandom);
            rst_n = ($urandom % 500 != 0);
            @(negedge clk);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles each digit stays enabled (>=2).
REQ-003 Parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (>=1).
REQ-004 Parameter SEG_ACTIVE_LOW, default 1, 1 inverts seg, dp and an at the pins (common-anode boards).
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 digits_bcd  in  4*NUM_DIGITS  BCD digits, digit 0 in bits [3:0] (least significant, rightmost).
REQ-008 dp_in  in  NUM_DIGITS  decimal point request per digit.
REQ-009 load  in  1  one-cycle strobe capturing digits_bcd and dp_in.
REQ-010 blank_lz  in  1  1 = leading-zero blanking enabled.
REQ-011 blink_mask  in  NUM_DIGITS  1 = digit blinks.
REQ-012 seg  out  7  segments {g,f,e,d,c,b,a}.
REQ-013 dp  out  1  decimal point of enabled digit.
REQ-014 an  out  NUM_DIGITS  one-hot digit enable.
REQ-015 frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Function
REQ-016 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-017 frame_done SHALL assert for exactly the cycle in which prescaler is at terminal count and index is NUM_DIGITS-1.
REQ-018 load SHALL capture digits_bcd/dp_in into a pending register; pending SHALL transfer to the active register on the frame_done cycle, so no frame mixes old and new data.
REQ-019 load coinciding with frame_done SHALL write the new inputs directly into both pending and active registers.
REQ-020 Multiple loads within one frame: last one wins.
REQ-021 Decode SHALL map 0-9 to standard 7-segment glyphs and codes 10-15 to dash (g only).
REQ-022 With blank_lz=1, each digit from NUM_DIGITS-1 downward SHALL be blanked while it and all more-significant digits are 0; digit 0 is never blanked by this rule.
REQ-023 Blanked digits SHALL drive seg=0 and dp=0 (logical), an still enabled.
REQ-024 Blink phase SHALL toggle after every BLINK_FRAMES frame_done pulses; in off phase digits with blink_mask set SHALL be blanked (seg and dp).
REQ-025 blank_lz and blink_mask SHALL be sampled live, not through load.
REQ-026 seg, dp, an SHALL be registered; values reflect digit index with one cycle latency.
REQ-027 Exactly one an bit SHALL be logically active at any time after the first post-reset cycle.
REQ-028 SEG_ACTIVE_LOW SHALL invert only at the final output stage; all internal logic active-high.

Reset
REQ-029 While rst_n=0: prescaler=0, index=0, blink phase=on, pending/active digits=0, dp registers=0.
REQ-030 While rst_n=0: an all inactive, seg all off, dp off, frame_done=0 (physical levels per SEG_ACTIVE_LOW).
REQ-031 Reset asserted mid-frame SHALL abort the scan and discard pending data; first cycle after release enables digit 0 at next edge.

Structure
REQ-032 Shared package display_pkg SHALL hold the 7-bit glyph constants for 0-9, SEG_DASH and SEG_BLANK.
REQ-033 Decoding SHALL live in one combinational sub-module bcd_to_7seg (4-bit in, 7-bit active-high out).
REQ-034 Counter widths SHALL be derived with $clog2 from REFRESH_DIV, NUM_DIGITS and BLINK_FRAMES.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2, SEG_ACTIVE_LOW=0)
REQ-035 Reset release, no load -> an cycles 0001,0010,0100,1000 each 4 cycles, seg=0111111 ("0"), frame_done every 16 cycles.
REQ-036 load 0x1259 mid-frame -> old digits until frame_done, next frame shows 9,5,2,1 (seg 1101111,1101101,1011011,0000110).
REQ-037 blank_lz=1, digits 0x0070 -> digits 3,2 seg=0, digit 1 "7", digit 0 "0"; digits 0x0000 -> only digit 0 lit.
REQ-038 digits 0x00AF -> digits 0,1 show dash 1000000.
REQ-039 blink_mask=0011 -> digits 0,1 lit 2 frames, blank 2 frames; digits 2,3 always lit.
REQ-040 rst_n low for 1 cycle in digit 2 slot after a pending load -> outputs off, restart at digit 0 showing zeros.
